div5_seq_ctrl: RTL and testbench

- Sequential controller for an unsigned 5-bit restoring divider.
- Sequences one shared 5-bit ripple add/sub datapath, used in subtract mode: `in_c`=1, B inverted, carry-in 1.
- Performs one trial subtraction per clock and returns quotient and remainder after WIDTH iterations.
- Sits beside the arithmetic lab datapath as the first multi-cycle consumer of the add/sub unit.

---
 rtl/div5_seq_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_div5_seq_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/div5_seq_ctrl.sv
// div5_seq_ctrl: sequential controller for an unsigned 5-bit restoring divider.
// One trial subtraction per clock on a shared 5-bit ripple add/sub datapath
// (subtract mode: in_c=1, B inverted, carry-in 1); results after WIDTH iterations.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   start      division request, sampled only in IDLE
//   dividend   unsigned dividend, latched on accepted start
//   divisor    unsigned divisor, latched on accepted start
//   busy       high from accept until the done cycle ends
//   done       one-cycle pulse, quotient/remainder valid
//   quotient   registered quotient, held until next accepted start
//   remainder  registered remainder, held until next accepted start
//   err        divide-by-zero flag
//
// Optional feature macro: DIV5_ZERO_TRAP_EN
//   defined   : divisor 0 skips RUN, done one cycle after accept, err=1 with done
//   undefined : err tied 0, divisor 0 runs the normal algorithm (quotient 31)
module div5_seq_ctrl #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             err
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] q_reg, q_nx;
    logic [WIDTH-1:0] d_reg, d_nx;
    logic [WIDTH-1:0] r_reg, r_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             busy_nx, done_nx;
    logic [WIDTH-1:0] quot_nx, rem_nx;

    // shared add/sub datapath signals
    logic [WIDTH-1:0] dp_a, dp_b, dp_diff;
    logic             dp_in_c, dp_c;

    logic [WIDTH-1:0] s_val;
    logic             ok;

    // Ripple add/sub: in_c=1 inverts B and injects carry-in 1 (subtract).
    always_comb begin
        logic carry;
        logic b_eff;
        dp_diff = '0;
        carry   = dp_in_c;
        for (int i = 0; i < int'(WIDTH); i++) begin
            b_eff      = dp_b[i] ^ dp_in_c;
            dp_diff[i] = dp_a[i] ^ b_eff ^ carry;
            carry      = (dp_a[i] & b_eff) | (carry & (dp_a[i] ^ b_eff));
        end
        dp_c = carry;
    end

    // Shifted partial remainder; r_reg[MSB] is its hidden sixth bit.
    assign s_val   = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
    assign dp_a    = s_val;
    assign dp_b    = d_reg;
    assign dp_in_c = 1'b1;
    // c=1 means no borrow; a shifted-out 1 makes S >= D regardless.
    assign ok      = r_reg[WIDTH-1] | dp_c;

`ifdef DIV5_ZERO_TRAP_EN
    logic err_nx;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_nx = state;
        q_nx     = q_reg;
        d_nx     = d_reg;
        r_nx     = r_reg;
        cnt_nx   = cnt;
        busy_nx  = busy;
        done_nx  = 1'b0;
        quot_nx  = quotient;
        rem_nx   = remainder;
`ifdef DIV5_ZERO_TRAP_EN
        err_nx   = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                busy_nx = 1'b0;
                if (start) begin
                    q_nx     = dividend;
                    d_nx     = divisor;
                    r_nx     = '0;
                    cnt_nx   = '0;
                    busy_nx  = 1'b1;
                    state_nx = RUN;
`ifdef DIV5_ZERO_TRAP_EN
                    // Preload the divide-by-zero answer and skip iterations.
                    if (divisor == '0) begin
                        q_nx     = '1;
                        r_nx     = dividend;
                        state_nx = DONE;
                    end
`endif
                end
            end
            RUN: begin
                busy_nx = 1'b1;
                r_nx    = ok ? dp_diff : s_val;
                q_nx    = {q_reg[WIDTH-2:0], ok};
                cnt_nx  = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy_nx  = 1'b1;
                done_nx  = 1'b1;
                quot_nx  = q_reg;
                rem_nx   = r_reg;
`ifdef DIV5_ZERO_TRAP_EN
                err_nx   = (d_reg == '0);
`endif
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, operand and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            q_reg     <= '0;
            d_reg     <= '0;
            r_reg     <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            state     <= state_nx;
            q_reg     <= q_nx;
            d_reg     <= d_nx;
            r_reg     <= r_nx;
            cnt       <= cnt_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            quotient  <= quot_nx;
            remainder <= rem_nx;
        end
    end

`ifdef DIV5_ZERO_TRAP_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err <= 1'b0;
        end else begin
            err <= err_nx;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_div5_seq_ctrl.sv
// Directed self-checking bench for div5_seq_ctrl.
module tb_div5_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [4:0] dividend;
    logic [4:0] divisor;
    logic       busy;
    logic       done;
    logic [4:0] quotient;
    logic [4:0] remainder;
    logic       err;

    int n_cmp = 0;
    int n_err = 0;

    div5_seq_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one operation and wait (bounded) for done; lat = edges after accept.
    task automatic run_op(input logic [4:0] a, input logic [4:0] b, output int lat);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        lat      = 0;
        while (done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int ndone;
        int exp_lat0;
        int exp_err0;

        reset_n  = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quot", quotient, 0);
        chk("rst_rem",  remainder, 0);
        chk("rst_err",  err, 0);
        reset_n = 1'b1;
        tick();

        // 23/5 with explicit cycle-by-cycle timing
        dividend = 5'd23;
        divisor  = 5'd5;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        chk("t1_busy_rise", busy, 1);
        for (int k = 1; k <= 5; k++) begin
            tick();
        end
        chk("t1_done_early", done, 0);
        tick();
        chk("t1_done", done, 1);
        chk("t1_busy_done", busy, 1);
        chk("t1_quot", quotient, 4);
        chk("t1_rem", remainder, 3);
        tick();
        chk("t1_busy_fall", busy, 0);
        chk("t1_done_fall", done, 0);

        // directed sweep with hold checks
        run_op(5'd31, 5'd1, lat);
        chk("s1_lat", lat, 6);
        chk("s1_quot", quotient, 31);
        chk("s1_rem", remainder, 0);
        for (int k = 0; k < 4; k++) tick();
        chk("s1_hold_quot", quotient, 31);
        chk("s1_hold_rem", remainder, 0);
        run_op(5'd7, 5'd9, lat);
        chk("s2_quot", quotient, 0);
        chk("s2_rem", remainder, 7);
        run_op(5'd30, 5'd30, lat);
        chk("s3_quot", quotient, 1);
        chk("s3_rem", remainder, 0);
        run_op(5'd0, 5'd7, lat);
        chk("s4_quot", quotient, 0);
        chk("s4_rem", remainder, 0);
        tick();

        // start pulses during RUN and DONE are ignored
        dividend = 5'd20;
        divisor  = 5'd3;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        ndone    = 0;
        for (int k = 1; k <= 7; k++) begin
            if (k == 3 || k == 6) begin
                dividend = 5'd9;
                divisor  = 5'd2;
                start    = 1'b1;
            end
            tick();
            start = 1'b0;
            if (done === 1'b1) begin
                ndone++;
                chk("ig_quot", quotient, 6);
                chk("ig_rem", remainder, 2);
            end
        end
        chk("ig_ndone", ndone, 1);
        chk("ig_busy_idle", busy, 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        chk("ig_no_second", ndone, 1);

        // asynchronous reset in the 3rd RUN cycle
        dividend = 5'd25;
        divisor  = 5'd4;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_done", done, 0);
        chk("ar_quot", quotient, 0);
        chk("ar_rem", remainder, 0);
        tick();
        tick();
        reset_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        chk("ar_no_done", ndone, 0);
        chk("ar_idle_busy", busy, 0);
        run_op(5'd25, 5'd4, lat);
        chk("ar_lat", lat, 6);
        chk("ar_quot2", quotient, 6);
        chk("ar_rem2", remainder, 1);
        tick();

        // divide by zero
`ifdef DIV5_ZERO_TRAP_EN
        exp_lat0 = 1;
        exp_err0 = 1;
`else
        exp_lat0 = 6;
        exp_err0 = 0;
`endif
        run_op(5'd13, 5'd0, lat);
        chk("z_lat", lat, exp_lat0);
        chk("z_quot", quotient, 31);
        chk("z_rem", remainder, 13);
        chk("z_err", err, exp_err0);
        tick();
        chk("z_err_clr", err, 0);

        // exhaustive nonzero-divisor sweep against integer division
        for (int a = 0; a < 32; a++) begin
            for (int b = 1; b < 32; b++) begin
                run_op(5'(a), 5'(b), lat);
                chk("ex_quot", quotient, 32'(a / b));
                chk("ex_rem", remainder, 32'(a % b));
            end
        end
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
